firebird7_in_gate2_edt_channel_in_demux_1x2: RTL and testbench

FIREBIRD7_IN_GATE2_EDT_CHANNEL_IN_DEMUX_1X2 -- requirements
Module: firebird7_in_gate2_edt_channel_in_demux_1x2

---
 rtl/firebird7_in_gate2_edt_pkg.sv | 19 +
 rtl/firebird7_in_gate2_edt_chan_pipe_stage.sv | 28 ++
 rtl/firebird7_in_gate2_edt_channel_in_demux_1x2.sv | 133 +++++++++++++
 tb/tb_firebird7_in_gate2_edt_channel_in_demux_1x2.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/firebird7_in_gate2_edt_pkg.sv
// rtl/firebird7_in_gate2_edt_pkg.sv - shared constants, beat record and helpers for the EDT channel demux
package firebird7_in_gate2_edt_pkg;

    localparam int EDT_PIPE_STAGES_MIN = 1;
    localparam int EDT_PIPE_STAGES_MAX = 4;
    localparam int EDT_CHAN_WIDTH_MAX  = 32;

    // Data is carried at maximum width; bits above CHAN_WIDTH are tied to zero and pruned.
    typedef struct packed {
        logic [EDT_CHAN_WIDTH_MAX-1:0] data;
        logic                          sel;
        logic                          valid;
    } edt_beat_t;

    function automatic int edt_fill_cnt_width(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/firebird7_in_gate2_edt_chan_pipe_stage.sv
// rtl/firebird7_in_gate2_edt_chan_pipe_stage.sv - one internal beat register with advance, flush and reset
module firebird7_in_gate2_edt_chan_pipe_stage
    import firebird7_in_gate2_edt_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      adv_i,
    input  logic      flush_i,
    input  edt_beat_t beat_i,
    output edt_beat_t beat_o
);

    edt_beat_t beat_q;

    // Flush drops only the valid bit so the data lines do not toggle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat_q <= '0;
        end else if (flush_i) begin
            beat_q.valid <= 1'b0;
        end else if (adv_i) begin
            beat_q <= beat_i;
        end
    end

    assign beat_o = beat_q;

endmodule

// File: rtl/firebird7_in_gate2_edt_channel_in_demux_1x2.sv
// rtl/firebird7_in_gate2_edt_channel_in_demux_1x2.sv - pipelined 1:2 scan channel demux
// Optional parity_out enabled by FIREBIRD7_EDT_CHAN_PARITY_EN.
module firebird7_in_gate2_edt_channel_in_demux_1x2
    import firebird7_in_gate2_edt_pkg::*;
#(
    parameter int CHAN_WIDTH  = 2,
    parameter int PIPE_STAGES = 2
) (
    input  logic                  edt_clock,
    input  logic                  edt_reset,
    input  logic                  edt_update,
    input  logic                  scan_en,
    input  logic                  dmx_sel,
    input  logic [CHAN_WIDTH-1:0] chan_in,
    output logic [CHAN_WIDTH-1:0] dmx_out0,
    output logic [CHAN_WIDTH-1:0] dmx_out1,
    output logic                  dmx_valid0,
    output logic                  dmx_valid1,
`ifdef FIREBIRD7_EDT_CHAN_PARITY_EN
    output logic                  parity_out,
`endif
    output logic                  pipe_full
);

    localparam int FILL_W = edt_fill_cnt_width(PIPE_STAGES);

    if (PIPE_STAGES < EDT_PIPE_STAGES_MIN || PIPE_STAGES > EDT_PIPE_STAGES_MAX) begin : g_bad_stages
        $error("PIPE_STAGES out of range");
    end
    if (CHAN_WIDTH < 1 || CHAN_WIDTH > EDT_CHAN_WIDTH_MAX) begin : g_bad_width
        $error("CHAN_WIDTH out of range");
    end

    logic advance;
    assign advance = scan_en & ~edt_update;

    // chain[0] is the incoming beat; chain[PIPE_STAGES-1] feeds the output registers.
    edt_beat_t chain [PIPE_STAGES];

    always_comb begin
        chain[0]       = '0;
        chain[0].data  = EDT_CHAN_WIDTH_MAX'(chan_in);
        chain[0].sel   = dmx_sel;
        chain[0].valid = 1'b1;
    end

    for (genvar i = 0; i < PIPE_STAGES - 1; i++) begin : g_stage
        firebird7_in_gate2_edt_chan_pipe_stage u_stage (
            .clk_i   (edt_clock),
            .rst_i   (edt_reset),
            .adv_i   (advance),
            .flush_i (edt_update),
            .beat_i  (chain[i]),
            .beat_o  (chain[i+1])
        );
    end

    edt_beat_t             out_beat;
    logic [CHAN_WIDTH-1:0] out_data;
    logic                  unused_beat_bits;

    assign out_beat         = chain[PIPE_STAGES-1];
    assign out_data         = out_beat.data[CHAN_WIDTH-1:0];
    assign unused_beat_bits = ^out_beat.data;

    logic [CHAN_WIDTH-1:0] out0_q, out0_d, out1_q, out1_d;
    logic                  valid0_q, valid0_d, valid1_q, valid1_d;
    logic [FILL_W-1:0]     fill_q, fill_d;
    logic                  parity_q, parity_d;

    always_comb begin
        out0_d   = out0_q;
        out1_d   = out1_q;
        valid0_d = valid0_q;
        valid1_d = valid1_q;
        fill_d   = fill_q;
        parity_d = parity_q;
        if (edt_update) begin
            valid0_d = 1'b0;
            valid1_d = 1'b0;
            fill_d   = '0;
            parity_d = 1'b0;
        end else if (scan_en) begin
            valid0_d = 1'b0;
            valid1_d = 1'b0;
            if (out_beat.valid) begin
                parity_d = parity_q ^ (^out_data);
                if (out_beat.sel) begin
                    out1_d   = out_data;
                    valid1_d = 1'b1;
                end else begin
                    out0_d   = out_data;
                    valid0_d = 1'b1;
                end
            end
            if (fill_q != FILL_W'(PIPE_STAGES)) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    always_ff @(posedge edt_clock) begin
        if (edt_reset) begin
            out0_q   <= '0;
            out1_q   <= '0;
            valid0_q <= 1'b0;
            valid1_q <= 1'b0;
            fill_q   <= '0;
            parity_q <= 1'b0;
        end else begin
            out0_q   <= out0_d;
            out1_q   <= out1_d;
            valid0_q <= valid0_d;
            valid1_q <= valid1_d;
            fill_q   <= fill_d;
            parity_q <= parity_d;
        end
    end

    assign dmx_out0   = out0_q;
    assign dmx_out1   = out1_q;
    assign dmx_valid0 = valid0_q;
    assign dmx_valid1 = valid1_q;
    assign pipe_full  = (fill_q == FILL_W'(PIPE_STAGES));

`ifdef FIREBIRD7_EDT_CHAN_PARITY_EN
    assign parity_out = parity_q;
`else
    logic unused_parity;
    assign unused_parity = parity_q;
`endif

endmodule

// File: tb/tb_firebird7_in_gate2_edt_channel_in_demux_1x2.sv
// tb/tb_firebird7_in_gate2_edt_channel_in_demux_1x2.sv - directed bench for the EDT channel demux
module tb_firebird7_in_gate2_edt_channel_in_demux_1x2;

    logic       clk = 1'b0;
    logic       edt_reset, edt_update, scan_en, dmx_sel;
    logic [1:0] chan_in;

    logic [1:0] a_out0, a_out1, b_out0, b_out1;
    logic       a_v0, a_v1, a_full, b_v0, b_v1, b_full;
`ifdef FIREBIRD7_EDT_CHAN_PARITY_EN
    logic       a_par, b_par;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    firebird7_in_gate2_edt_channel_in_demux_1x2 #(.CHAN_WIDTH(2), .PIPE_STAGES(2)) u_dut2 (
        .edt_clock  (clk),
        .edt_reset  (edt_reset),
        .edt_update (edt_update),
        .scan_en    (scan_en),
        .dmx_sel    (dmx_sel),
        .chan_in    (chan_in),
        .dmx_out0   (a_out0),
        .dmx_out1   (a_out1),
        .dmx_valid0 (a_v0),
        .dmx_valid1 (a_v1),
`ifdef FIREBIRD7_EDT_CHAN_PARITY_EN
        .parity_out (a_par),
`endif
        .pipe_full  (a_full)
    );

    firebird7_in_gate2_edt_channel_in_demux_1x2 #(.CHAN_WIDTH(2), .PIPE_STAGES(1)) u_dut1 (
        .edt_clock  (clk),
        .edt_reset  (edt_reset),
        .edt_update (edt_update),
        .scan_en    (scan_en),
        .dmx_sel    (dmx_sel),
        .chan_in    (chan_in),
        .dmx_out0   (b_out0),
        .dmx_out1   (b_out1),
        .dmx_valid0 (b_v0),
        .dmx_valid1 (b_v1),
`ifdef FIREBIRD7_EDT_CHAN_PARITY_EN
        .parity_out (b_par),
`endif
        .pipe_full  (b_full)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic rst, input logic upd, input logic en,
                        input logic sel, input logic [1:0] d);
        edt_reset  = rst;
        edt_update = upd;
        scan_en    = en;
        dmx_sel    = sel;
        chan_in    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [1:0] o0, input logic [1:0] o1,
                         input logic v0, input logic v1, input logic full);
        check({tag, ".out0"}, 32'(a_out0), 32'(o0));
        check({tag, ".out1"}, 32'(a_out1), 32'(o1));
        check({tag, ".v0"},   32'(a_v0),   32'(v0));
        check({tag, ".v1"},   32'(a_v1),   32'(v1));
        check({tag, ".full"}, 32'(a_full), 32'(full));
    endtask

    initial begin
        edt_reset  = 1'b1;
        edt_update = 1'b0;
        scan_en    = 1'b0;
        dmx_sel    = 1'b0;
        chan_in    = 2'd0;

        // Reset state
        step(1, 0, 1, 1, 2'd3);
        chk_a("rst", 2'd0, 2'd0, 0, 0, 0);

        // Basic stream 1,2,3,0 with sel 0,1,0,1
        step(0, 0, 1, 0, 2'd1); chk_a("s_adv1", 2'd0, 2'd0, 0, 0, 0);
        step(0, 0, 1, 1, 2'd2); chk_a("s_adv2", 2'd1, 2'd0, 1, 0, 1);
        step(0, 0, 1, 0, 2'd3); chk_a("s_adv3", 2'd1, 2'd2, 0, 1, 1);
        step(0, 0, 1, 1, 2'd0); chk_a("s_adv4", 2'd3, 2'd2, 1, 0, 1);

        // Same stream with scan_en gaps
        step(1, 0, 0, 0, 2'd0);
        step(0, 0, 1, 0, 2'd1); chk_a("g_adv1", 2'd0, 2'd0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, i[0], 2'(i + 2));
            chk_a("g_idle", 2'd0, 2'd0, 0, 0, 0);
        end
        step(0, 0, 1, 1, 2'd2); chk_a("g_adv2", 2'd1, 2'd0, 1, 0, 1);
        step(0, 0, 0, 0, 2'd3); chk_a("g_hold", 2'd1, 2'd0, 1, 0, 1);
        step(0, 0, 1, 0, 2'd3); chk_a("g_adv3", 2'd1, 2'd2, 0, 1, 1);
        step(0, 0, 1, 1, 2'd0); chk_a("g_adv4", 2'd3, 2'd2, 1, 0, 1);

        // Flush with scan_en high while beats are in flight
        step(1, 0, 0, 0, 2'd0);
        step(0, 0, 1, 0, 2'd1);
        step(0, 0, 1, 1, 2'd2); chk_a("u_pre",  2'd1, 2'd0, 1, 0, 1);
        step(0, 1, 1, 0, 2'd3); chk_a("u_upd",  2'd1, 2'd0, 0, 0, 0);
        step(0, 0, 1, 1, 2'd1); chk_a("u_adv1", 2'd1, 2'd0, 0, 0, 0);
        step(0, 0, 1, 0, 2'd2); chk_a("u_adv2", 2'd1, 2'd1, 0, 1, 1);

        // Reset mid-stream discards in-flight beats
        step(1, 0, 0, 0, 2'd0);
        step(0, 0, 1, 0, 2'd1);
        step(0, 0, 1, 1, 2'd2);
        step(1, 0, 1, 0, 2'd3); chk_a("r_rst",  2'd0, 2'd0, 0, 0, 0);
        step(0, 0, 1, 0, 2'd0); chk_a("r_adv1", 2'd0, 2'd0, 0, 0, 0);
        step(0, 0, 1, 1, 2'd0); chk_a("r_adv2", 2'd0, 2'd0, 1, 0, 1);

        // Single-stage build: input lands on the outputs in one advance
        step(1, 0, 0, 0, 2'd0);
        step(0, 0, 1, 1, 2'd2);
        check("p1_out1", 32'(b_out1), 32'd2);
        check("p1_v1",   32'(b_v1),   32'd1);
        check("p1_out0", 32'(b_out0), 32'd0);
        check("p1_v0",   32'(b_v0),   32'd0);
        check("p1_full", 32'(b_full), 32'd1);
        step(0, 0, 1, 0, 2'd1);
        check("p1b_out0", 32'(b_out0), 32'd1);
        check("p1b_v0",   32'(b_v0),   32'd1);
        check("p1b_v1",   32'(b_v1),   32'd0);
        check("p1b_out1", 32'(b_out1), 32'd2);

`ifdef FIREBIRD7_EDT_CHAN_PARITY_EN
        // Delivered beats 1,3,2 then 1, then a flush
        step(1, 0, 0, 0, 2'd0);
        check("par_rst", 32'(a_par), 32'd0);
        step(0, 0, 1, 0, 2'd1);
        step(0, 0, 1, 1, 2'd3); check("par_b1", 32'(a_par), 32'd1);
        step(0, 0, 1, 0, 2'd2); check("par_b3", 32'(a_par), 32'd1);
        step(0, 0, 1, 0, 2'd1); check("par_b2", 32'(a_par), 32'd0);
        step(0, 0, 1, 0, 2'd0); check("par_b4", 32'(a_par), 32'd1);
        step(0, 1, 1, 0, 2'd0); check("par_upd", 32'(a_par), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
